// File: rtl/qdr_arb_pkg.sv
// qdr_arb_pkg: shared types and default widths for the QDR user-port arbiter
package qdr_arb_pkg;
    localparam int DEF_ADDR_WIDTH = 22;
    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_BE_WIDTH   = 4;
    localparam int DEF_TAG_DEPTH  = 32;

    typedef enum logic [1:0] {WAIT_PHY, RUN, FAULT} arb_state_t;

    typedef logic req_id_t;
endpackage

// File: rtl/qdr_tag_fifo.sv
// qdr_tag_fifo: DEPTH x 1-bit requester-ID FIFO, first-word-fall-through read port
module qdr_tag_fifo
    import qdr_arb_pkg::*;
#(
    parameter int DEPTH = DEF_TAG_DEPTH
) (
    input  logic    clk0,
    input  logic    reset_n,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t pop_id,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    req_id_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_id  = mem[rd_ptr];

    always_ff @(posedge clk0) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk0)
        if (do_push) mem[wr_ptr] <= push_id;
endmodule

// File: rtl/qdr_user_arbiter.sv
// qdr_user_arbiter: two-master arbiter onto one QDR user port; QDR_ARB_FIXED_PRIO_EN selects fixed m0 priority
module qdr_user_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DEF_BE_WIDTH,
    parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
    input  logic                  clk0,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    input  logic [BE_WIDTH-1:0]   m0_wr_be,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_rd_dvld,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    input  logic [BE_WIDTH-1:0]   m1_wr_be,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_rd_dvld,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wr_data,
    output logic [BE_WIDTH-1:0]   usr_wr_be,
    output logic                  usr_wr_strb,
    output logic                  usr_rd_strb,
    input  logic [DATA_WIDTH-1:0] usr_rd_data,
    input  logic                  usr_rd_dvld,
    input  logic                  phy_rdy,
    input  logic                  cal_fail,
    output logic                  arb_fault
);
    arb_state_t state, state_next;
    logic run, full, empty, el0, el1, grant, sel_we, pop, orphan;
    req_id_t sel, pop_id;

    always_ff @(posedge clk0)
        state <= !reset_n ? WAIT_PHY : state_next;

    always_comb
        state_next = (cal_fail || state == FAULT) ? FAULT : phy_rdy ? RUN : WAIT_PHY;

    always_comb
        run = reset_n && state == RUN;

    // Reads need a free tag slot; writes never wait on the FIFO
    assign el0   = m0_req && (m0_we || !full);
    assign el1   = m1_req && (m1_we || !full);
    assign grant = run && (el0 || el1);

`ifdef QDR_ARB_FIXED_PRIO_EN
    assign sel = !el0;
`else
    req_id_t last;
    always_ff @(posedge clk0)
        last <= !reset_n ? 1'b1 : grant ? sel : last;
    assign sel = (el0 && el1) ? !last : el1;
`endif

    assign m0_ack = grant && !sel;
    assign m1_ack = grant && sel;
    assign sel_we = sel ? m1_we : m0_we;
    assign pop    = usr_rd_dvld && !empty;
    assign orphan = usr_rd_dvld && empty;

    qdr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk0    (clk0),
        .reset_n (reset_n),
        .push    (grant && !sel_we),
        .push_id (sel),
        .pop     (pop),
        .pop_id  (pop_id),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk0) begin
        if (!reset_n) begin
            usr_addr    <= '0;
            usr_wr_data <= '0;
            usr_wr_be   <= '0;
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
            m0_rd_dvld  <= 1'b0;
            m1_rd_dvld  <= 1'b0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            arb_fault   <= 1'b0;
        end else begin
            usr_wr_strb <= grant && sel_we;
            usr_rd_strb <= grant && !sel_we;
            if (grant) begin
                usr_addr    <= sel ? m1_addr : m0_addr;
                usr_wr_data <= sel ? m1_wr_data : m0_wr_data;
                usr_wr_be   <= sel ? m1_wr_be : m0_wr_be;
            end
            m0_rd_dvld <= pop && !pop_id;
            m1_rd_dvld <= pop && pop_id;
            if (pop && !pop_id) m0_rd_data <= usr_rd_data;
            if (pop && pop_id) m1_rd_data <= usr_rd_data;
            arb_fault <= arb_fault || cal_fail || orphan;
        end
    end
endmodule

// File: tb/tb_qdr_user_arbiter.sv
// tb_qdr_user_arbiter: randomized + directed scoreboard bench against a queue-based reference model
module tb_qdr_user_arbiter;
    localparam int AW = 22, DW = 36, BW = 4, DEPTH = 32;
`ifdef QDR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk0 = 1'b0, reset_n;
    logic m0_req, m0_we, m1_req, m1_we, m0_ack, m1_ack, m0_rd_dvld, m1_rd_dvld;
    logic [AW-1:0] m0_addr, m1_addr, usr_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data, usr_wr_data, usr_rd_data;
    logic [BW-1:0] m0_wr_be, m1_wr_be, usr_wr_be;
    logic usr_wr_strb, usr_rd_strb, usr_rd_dvld, phy_rdy, cal_fail, arb_fault;

    always #5 clk0 = !clk0;

    qdr_user_arbiter dut (
        .clk0(clk0), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_wr_be(m0_wr_be),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data), .m0_rd_dvld(m0_rd_dvld),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_wr_be(m1_wr_be),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data), .m1_rd_dvld(m1_rd_dvld),
        .usr_addr(usr_addr), .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be),
        .usr_wr_strb(usr_wr_strb), .usr_rd_strb(usr_rd_strb),
        .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
        .phy_rdy(phy_rdy), .cal_fail(cal_fail), .arb_fault(arb_fault)
    );

    int ncmp = 0, nfail = 0;
    logic [62:0] cmd_q[$];
    logic [36:0] rd_q[$];
    bit tagq[$];
    bit running = 0, faulted = 0, fault = 0, last = 1, prev_rst = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: evaluates one cycle's inputs just before the clock edge
    task automatic tick();
        bit el0, el1, g, w, we;
        #1;
        chk("arb_fault", 64'(arb_fault), 64'(fault));
        if (prev_rst)
            chk("reset_outputs_zero", 64'(|{usr_addr, usr_wr_data, usr_wr_be, usr_wr_strb, usr_rd_strb,
                m0_rd_dvld, m1_rd_dvld, m0_rd_data, m1_rd_data}), 64'(0));
        if (!reset_n) begin
            chk("m0_ack_in_reset", 64'(m0_ack), 64'(0));
            chk("m1_ack_in_reset", 64'(m1_ack), 64'(0));
            tagq.delete();
            running = 0; faulted = 0; fault = 0; last = 1;
        end else begin
            el0 = m0_req && (m0_we || tagq.size() < DEPTH);
            el1 = m1_req && (m1_we || tagq.size() < DEPTH);
            g = running && (el0 || el1);
            w = (el0 && el1) ? (FIXED ? 1'b0 : !last) : el1;
            chk("m0_ack", 64'(m0_ack), 64'(g && !w));
            chk("m1_ack", 64'(m1_ack), 64'(g && w));
            if (usr_rd_dvld) begin
                if (tagq.size() > 0) rd_q.push_back({tagq.pop_front(), usr_rd_data});
                else fault = 1;
            end
            if (cal_fail) fault = 1;
            if (g) begin
                we = w ? m1_we : m0_we;
                cmd_q.push_back(w ? {m1_we, m1_addr, m1_wr_data, m1_wr_be} : {m0_we, m0_addr, m0_wr_data, m0_wr_be});
                if (!we) tagq.push_back(w);
                last = w;
            end
            faulted = faulted || cal_fail;
            running = !faulted && phy_rdy;
        end
        prev_rst = !reset_n;
        @(negedge clk0);
    endtask

    always @(posedge clk0) begin
        logic [62:0] c;
        logic [36:0] r;
        #1;
        if (reset_n === 1'b1 || prev_rst) begin
            if (usr_wr_strb || usr_rd_strb) begin
                chk("single_strobe", 64'(usr_wr_strb && usr_rd_strb), 64'(0));
                chk("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    chk("cmd_we", 64'(usr_wr_strb), 64'(c[62]));
                    chk("cmd_addr", 64'(usr_addr), 64'(c[61:40]));
                    if (c[62]) begin
                        chk("cmd_wr_data", 64'(usr_wr_data), 64'(c[39:4]));
                        chk("cmd_wr_be", 64'(usr_wr_be), 64'(c[3:0]));
                    end
                end
            end
            if (m0_rd_dvld || m1_rd_dvld) begin
                chk("single_rd_dvld", 64'(m0_rd_dvld && m1_rd_dvld), 64'(0));
                chk("rd_expected", 64'(rd_q.size() != 0), 64'(1));
                if (rd_q.size() != 0) begin
                    r = rd_q.pop_front();
                    chk("rd_id", 64'(m1_rd_dvld), 64'(r[36]));
                    chk("rd_data", 64'(r[36] ? m1_rd_data : m0_rd_data), 64'(r[35:0]));
                end
            end
        end
    end

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        usr_rd_dvld = 0; usr_rd_data = '0; cal_fail = 0;
    endtask

    task automatic rand_cmds(bit r0, bit r1, bit w0, bit w1);
        m0_req = r0; m1_req = r1; m0_we = w0; m1_we = w1;
        m0_addr = 22'($urandom()); m1_addr = 22'($urandom());
        m0_wr_data = 36'({$urandom(), $urandom()}); m1_wr_data = 36'({$urandom(), $urandom()});
        m0_wr_be = 4'($urandom()); m1_wr_be = 4'($urandom());
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 100 && tagq.size() > 0; i++) begin
            usr_rd_dvld = 1; usr_rd_data = 36'({$urandom(), $urandom()});
            tick();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle(); rand_cmds(1, 1, 1, 1);
        reset_n = 0; phy_rdy = 0; usr_rd_data = '0;
        repeat (2) @(negedge clk0);
        repeat (2) tick();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin rand_cmds(1, 1, 1, 1); tick(); end
        phy_rdy = 1;
        rand_cmds(1, 1, 1, 1); tick();
        rand_cmds(1, 1, 1, 1);
        #1;
        chk("first_ack_m0", 64'(m0_ack), 64'(1));
        chk("first_ack_not_m1", 64'(m1_ack), 64'(0));
        tick();
        for (int i = 0; i < 8; i++) begin rand_cmds(1, 1, 1, 1); tick(); end
        idle(); tick(); tick();

        rand_cmds(1, 0, 0, 0); m0_addr = 22'h000010; tick();
        rand_cmds(0, 1, 0, 0); m1_addr = 22'h000020; tick();
        idle(); tick();
        usr_rd_dvld = 1; usr_rd_data = 36'h0AAAA; tick();
        usr_rd_data = 36'h0BBBB; tick();
        idle(); tick(); tick();

        for (int i = 0; i < 200 && tagq.size() < DEPTH; i++) begin rand_cmds(1, 1, 0, 1); tick(); end
        rand_cmds(1, 1, 0, 1);
        #1;
        chk("full_read_held", 64'(m0_ack), 64'(0));
        chk("full_write_acked", 64'(m1_ack), 64'(1));
        tick();
        rand_cmds(1, 1, 0, 1); usr_rd_dvld = 1; usr_rd_data = 36'h123456789; tick();
        usr_rd_dvld = 0; rand_cmds(1, 0, 0, 0);
        #1;
        chk("read_reenabled", 64'(m0_ack), 64'(1));
        tick();
        drain();

        for (int i = 0; i < 400; i++) begin
            rand_cmds(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            usr_rd_dvld = tagq.size() > 0 && $urandom_range(0, 2) == 0;
            usr_rd_data = 36'({$urandom(), $urandom()});
            if ($urandom_range(0, 40) == 0) phy_rdy = !phy_rdy;
            tick();
        end
        phy_rdy = 1;
        drain();
        tick();

        usr_rd_dvld = 1; usr_rd_data = 36'h0DEAD; tick();
        idle(); tick();
        chk("orphan_fault", 64'(arb_fault), 64'(1));
        tick();

        rand_cmds(1, 1, 0, 1); tick();
        rand_cmds(1, 1, 1, 0); reset_n = 0; tick();
        reset_n = 1; idle(); tick(); tick();

        rand_cmds(1, 1, 1, 1); cal_fail = 1; tick();
        cal_fail = 0;
        for (int i = 0; i < 6; i++) begin rand_cmds(1, 1, 1, 0); tick(); end
        drain();
        reset_n = 0; tick();
        reset_n = 1; tick();
        usr_rd_dvld = 1; usr_rd_data = 36'h0BEEF; tick();
        idle();
        repeat (3) tick();

        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end
endmodule
